freq_div_sequencer: RTL and testbench

Programmable controller that sequences one external frequency divider through a table of divide settings. Each table entry holds the divider switch value, the high/low range select, and a duration counted in divider carry-out pulses. On start it loads each entry into the divider with a one-cycle init pulse, counts carry-outs, then advances. It either stops at the end of the table or loops. Typical use is tone/rate scheduling for the board's clock-divider datapath.

---
 rtl/fdseq_pkg.sv | 28 ++
 rtl/fdseq_table.sv | 48 ++++
 rtl/freq_div_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_freq_div_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdseq_pkg.sv
// Shared types and defaults for the frequency-divider sequencer.
// Optional build macro used by this slice: FDSEQ_PASS_CNT_EN.
package fdseq_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_SW_W  = 3;
    localparam int DEF_DUR_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } fdseq_state_e;

    // One table entry at the default widths.
    typedef struct packed {
        logic [DEF_SW_W-1:0]  sw;
        logic                 hl;
        logic [DEF_DUR_W-1:0] dur;
    } fdseq_entry_t;

    // Saturating 8-bit increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fdseq_table.sv
// DEPTH-entry table of divider settings: gated synchronous write,
// asynchronous read, asynchronous active-low clear.
module fdseq_table
    import fdseq_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int SW_W  = DEF_SW_W,
    parameter  int DUR_W = DEF_DUR_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_allow,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [SW_W-1:0]  wr_sw,
    input  logic             wr_hl,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [AW-1:0]    rd_addr,
    output logic [SW_W-1:0]  rd_sw,
    output logic             rd_hl,
    output logic [DUR_W-1:0] rd_dur
);

    logic [SW_W-1:0]  sw_mem  [DEPTH];
    logic             hl_mem  [DEPTH];
    logic [DUR_W-1:0] dur_mem [DEPTH];

    // Store an entry when a write arrives while the sequencer is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sw_mem[i]  <= '0;
                hl_mem[i]  <= 1'b0;
                dur_mem[i] <= '0;
            end
        end else if (wr_en && write_allow) begin
            sw_mem[wr_addr]  <= wr_sw;
            hl_mem[wr_addr]  <= wr_hl;
            dur_mem[wr_addr] <= wr_dur;
        end
    end

    assign rd_sw  = sw_mem[rd_addr];
    assign rd_hl  = hl_mem[rd_addr];
    assign rd_dur = dur_mem[rd_addr];

endmodule

// File: rtl/freq_div_sequencer.sv
// Steps an external frequency divider through a table of settings.
// Each entry is loaded with a one-cycle div_init pulse and held for
// 'dur' divider carry-outs. Optional macro FDSEQ_PASS_CNT_EN adds a
// saturating count of completed passes through the table.
// Handshake: div_co is a single-cycle pulse, counted only in RUN;
// div_init and done are single-cycle pulses; all outputs are registered.
module freq_div_sequencer
    import fdseq_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int SW_W  = DEF_SW_W,
    parameter  int DUR_W = DEF_DUR_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [SW_W-1:0]  wr_sw,
    input  logic             wr_hl,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic [LW-1:0]    len,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
    input  logic             div_co,
    output logic             div_init,
    output logic [SW_W-1:0]  div_sw,
    output logic             div_hl,
    output logic             tick_out,
    output logic [AW-1:0]    step_idx,
    output logic             busy,
    output logic             done,
    output fdseq_state_e     state_dbg
`ifdef FDSEQ_PASS_CNT_EN
    ,
    output logic [7:0]       pass_cnt
`endif
);

    fdseq_state_e     state, state_n;
    logic [AW-1:0]    step_idx_n, rd_addr;
    logic [LW-1:0]    len_q, len_q_n;
    logic             loop_q, loop_q_n;
    logic [DUR_W-1:0] dur_cnt, dur_cnt_n, dur_load;
    logic             div_init_n, div_hl_n, tick_n, busy_n, done_n;
    logic [SW_W-1:0]  div_sw_n;
    logic [SW_W-1:0]  rd_sw;
    logic             rd_hl;
    logic [DUR_W-1:0] rd_dur;
    logic             last_entry;
`ifdef FDSEQ_PASS_CNT_EN
    logic [7:0]       pass_n;
`endif

    fdseq_table #(.DEPTH(DEPTH), .SW_W(SW_W), .DUR_W(DUR_W)) u_table (
        .clk        (clk),
        .rst        (rst),
        .write_allow(!busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_sw      (wr_sw),
        .wr_hl      (wr_hl),
        .wr_dur     (wr_dur),
        .rd_addr    (rd_addr),
        .rd_sw      (rd_sw),
        .rd_hl      (rd_hl),
        .rd_dur     (rd_dur)
    );

    // Entry to load next: the following one in RUN, otherwise entry 0.
    assign last_entry = ({1'b0, step_idx} + LW'(1)) >= len_q;
    assign rd_addr    = (state == RUN && !last_entry) ? step_idx + AW'(1) : '0;
    assign dur_load   = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
    assign state_dbg  = state;

    // Next-state and next-output decode.
    always_comb begin
        state_n    = state;
        step_idx_n = step_idx;
        len_q_n    = len_q;
        loop_q_n   = loop_q;
        dur_cnt_n  = dur_cnt;
        div_init_n = 1'b0;
        div_sw_n   = div_sw;
        div_hl_n   = div_hl;
        tick_n     = 1'b0;
        busy_n     = busy;
        done_n     = 1'b0;
`ifdef FDSEQ_PASS_CNT_EN
        pass_n     = pass_cnt;
`endif
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
`ifdef FDSEQ_PASS_CNT_EN
                    pass_n = '0;
`endif
                    if (len != '0) begin
                        len_q_n    = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
                        loop_q_n   = loop;
                        step_idx_n = '0;
                        div_init_n = 1'b1;
                        div_sw_n   = rd_sw;
                        div_hl_n   = rd_hl;
                        dur_cnt_n  = dur_load;
                        busy_n     = 1'b1;
                        state_n    = LOAD;
                    end else begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            LOAD: begin
                if (stop) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (div_co) begin
                    tick_n    = 1'b1;
                    dur_cnt_n = dur_cnt - DUR_W'(1);
                    if (dur_cnt <= DUR_W'(1)) begin
                        if (!last_entry || loop_q) begin
                            step_idx_n = rd_addr;
                            div_init_n = 1'b1;
                            div_sw_n   = rd_sw;
                            div_hl_n   = rd_hl;
                            dur_cnt_n  = dur_load;
                            state_n    = LOAD;
`ifdef FDSEQ_PASS_CNT_EN
                            if (last_entry) pass_n = sat_inc8(pass_cnt);
`endif
                        end else begin
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                            state_n = DONE;
`ifdef FDSEQ_PASS_CNT_EN
                            pass_n  = sat_inc8(pass_cnt);
`endif
                        end
                    end
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            step_idx <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            dur_cnt  <= '0;
            div_init <= 1'b0;
            div_sw   <= '0;
            div_hl   <= 1'b0;
            tick_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef FDSEQ_PASS_CNT_EN
            pass_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            step_idx <= step_idx_n;
            len_q    <= len_q_n;
            loop_q   <= loop_q_n;
            dur_cnt  <= dur_cnt_n;
            div_init <= div_init_n;
            div_sw   <= div_sw_n;
            div_hl   <= div_hl_n;
            tick_out <= tick_n;
            busy     <= busy_n;
            done     <= done_n;
`ifdef FDSEQ_PASS_CNT_EN
            pass_cnt <= pass_n;
`endif
        end
    end

endmodule

// File: tb/tb_freq_div_sequencer.sv
// Bench for freq_div_sequencer: expected div_init/done events are queued
// from a table-walk model when a sequence is launched; a monitor pops and
// compares each event the DUT presents.
`timescale 1ns/1ps
module tb_freq_div_sequencer;
    import fdseq_pkg::*;

    localparam int DEPTH = 8;
    localparam int SW_W  = 3;
    localparam int DUR_W = 8;
    localparam int AW    = 3;
    localparam int LW    = 4;
    localparam int EW    = 2 + AW + SW_W + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [SW_W-1:0]  wr_sw = '0;
    logic             wr_hl = 1'b0;
    logic [DUR_W-1:0] wr_dur = '0;
    logic [LW-1:0]    len = '0;
    logic             loop = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             div_co = 1'b0;
    logic             div_init, div_hl, tick_out, busy, done;
    logic [SW_W-1:0]  div_sw;
    logic [AW-1:0]    step_idx;
    fdseq_state_e     state_dbg;
`ifdef FDSEQ_PASS_CNT_EN
    logic [7:0]       pass_cnt;
`endif

    freq_div_sequencer #(.DEPTH(DEPTH), .SW_W(SW_W), .DUR_W(DUR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_sw    (wr_sw),
        .wr_hl    (wr_hl),
        .wr_dur   (wr_dur),
        .len      (len),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .div_co   (div_co),
        .div_init (div_init),
        .div_sw   (div_sw),
        .div_hl   (div_hl),
        .tick_out (tick_out),
        .step_idx (step_idx),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
`ifdef FDSEQ_PASS_CNT_EN
        ,
        .pass_cnt (pass_cnt)
`endif
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_act;
    fdseq_entry_t  mt [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] ev_load(input int idx);
        return {2'd1, AW'(idx), mt[idx].sw, mt[idx].hl};
    endfunction

    function automatic logic [EW-1:0] ev_done();
        return {2'd2, {(EW-2){1'b0}}};
    endfunction

    function automatic int eff_dur(input int idx);
        return (mt[idx].dur == '0) ? 1 : int'(mt[idx].dur);
    endfunction

    // Monitor: every div_init or done pulse is one event.
    always @(negedge clk) begin
        if (rst) begin
            if (tick_out) tick_seen++;
            if (div_init || done) begin
                mon_act = div_init ? {2'd1, step_idx, div_sw, div_hl} : {2'd2, {(EW-2){1'b0}}};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got %0h expected none", mon_act);
                end else begin
                    check("event", mon_act, exp_q.pop_front());
                end
                if (div_init) check("busy_in_load", busy, 1);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int a, input int sw, input bit hl, input int dur, input bit upd);
        wr_en = 1'b1; wr_addr = AW'(a); wr_sw = SW_W'(sw); wr_hl = hl; wr_dur = DUR_W'(dur);
        cyc();
        wr_en = 1'b0;
        if (upd) begin
            mt[a].sw  = SW_W'(sw);
            mt[a].hl  = hl;
            mt[a].dur = DUR_W'(dur);
        end
    endtask

    // Reference: walk the table entry by entry, consuming carry-outs.
    task automatic model(input int l, input bit lp, input int n_co, output int acc, output int passes);
        int eff, idx, rem;
        eff = (l > DEPTH) ? DEPTH : l;
        acc = 0; passes = 0; idx = 0;
        if (eff == 0) begin
            exp_q.push_back(ev_done());
            return;
        end
        exp_q.push_back(ev_load(0));
        rem = eff_dur(0);
        for (int k = 0; k < n_co; k++) begin
            acc++;
            rem--;
            if (rem == 0) begin
                if (idx < eff - 1) idx++;
                else if (lp) begin idx = 0; passes++; end
                else begin
                    passes++;
                    exp_q.push_back(ev_done());
                    return;
                end
                exp_q.push_back(ev_load(idx));
                rem = eff_dur(idx);
            end
        end
    endtask

    // stop_mode: 0 none, 1 stop alone, 2 stop together with div_co.
    task automatic run_seq(input int l, input bit lp, input int n_co, input int stop_mode, input bit wr_mid);
        int acc, passes, eff;
        model(l, lp, n_co, acc, passes);
        eff = (l > DEPTH) ? DEPTH : l;
        tick_seen = 0;
        len = LW'(l); loop = lp; start = 1'b1;
        cyc();
        start = 1'b0;
        if (eff == 0) check("zero_len_done", done, 1);
        else          check("load_latency", div_init, 1);
        cyc();
        for (int k = 0; k < acc; k++) begin
            div_co = 1'b1;
            cyc();
            div_co = 1'b0;
            if (wr_mid && k == 0) wr(0, 7, 1'b1, 5, 1'b0);
            cyc($urandom_range(1, 3));
        end
        if (stop_mode != 0) begin
            div_co = (stop_mode == 2);
            stop = 1'b1;
            cyc();
            stop = 1'b0; div_co = 1'b0;
            check("stop_busy", busy, 0);
        end
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) cyc();
        cyc(3);
        check("events_drained", exp_q.size(), 0);
        exp_q.delete();
        check("tick_count", tick_seen, acc);
        check("busy_after", busy, 0);
`ifdef FDSEQ_PASS_CNT_EN
        check("pass_cnt", pass_cnt, passes);
`endif
    endtask

    // Stimulus and final report.
    initial begin
        for (int i = 0; i < DEPTH; i++) mt[i] = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_div_init", div_init, 0);
        check("rst_done", done, 0);
        check("rst_div_sw", div_sw, 0);
        check("rst_step_idx", step_idx, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(2);

        // Two-entry table, single pass then looping with stop.
        wr(0, 3, 1'b0, 2, 1'b1);
        wr(1, 5, 1'b1, 1, 1'b1);
        run_seq(2, 1'b0, 64, 0, 1'b0);
        run_seq(2, 1'b1, 5, 1, 1'b0);
        run_seq(2, 1'b1, 1, 2, 1'b0);

        // Empty sequence.
        run_seq(0, 1'b0, 64, 0, 1'b0);

        // Zero duration entry and a dropped write during a run.
        wr(2, 6, 1'b1, 0, 1'b1);
        wr(3, 2, 1'b0, 1, 1'b1);
        run_seq(4, 1'b0, 64, 0, 1'b1);
        run_seq(1, 1'b0, 64, 0, 1'b0);

        // Random tables, lengths (including over DEPTH) and loop modes.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++)
                wr(i, $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
            if ($urandom_range(0, 1) == 1)
                run_seq($urandom_range(0, 12), 1'b1, $urandom_range(1, 10), $urandom_range(1, 2), 1'b0);
            else
                run_seq($urandom_range(0, 12), 1'b0, 64, 0, 1'b0);
        end

        // Asynchronous reset while entry 1 is being loaded.
        wr(0, 3, 1'b0, 2, 1'b1);
        wr(1, 5, 1'b1, 1, 1'b1);
        exp_q.push_back(ev_load(0));
        exp_q.push_back(ev_load(1));
        len = LW'(2); loop = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        div_co = 1'b1; cyc(); div_co = 1'b0;
        cyc(2);
        div_co = 1'b1; cyc(); div_co = 1'b0;
        check("pre_rst_step_idx", step_idx, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_div_init", div_init, 0);
        check("arst_tick_out", tick_out, 0);
        check("arst_done", done, 0);
        check("arst_step_idx", step_idx, 0);
        check("arst_div_sw", div_sw, 0);
        check("arst_state", state_dbg, IDLE);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) mt[i] = '0;
        @(negedge clk);
        rst = 1'b1;
        cyc(2);
        run_seq(1, 1'b0, 64, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
